// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller and the
// digit sequence generator.
//   digit_t    : one display-buffer entry {blank, dp, data[3:0]}
//   state_t    : scan FSM states {BLANK, DRIVE}
//   HEX7_TABLE : nibble -> {g,f,e,d,c,b,a}, active-high
package seg_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] data;
  } digit_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Element 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to 7-segment decoder.
//   nibble_i : hex value 0x0..0xF
//   seg_o    : {g,f,e,d,c,b,a}, active-high
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexes a shared 7-segment bus across NUM_DIGITS common-anode
// digits, with dead-time blanking at the start of every digit slot.
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data/
//   wr_dp/wr_blank           : display-buffer write port
//   seg, dp                  : segment bus, active-high
//   an                       : digit enables, active-low
//   frame_tick               : one-cycle pulse when the digit index wraps to 0
//
// state | meaning
// BLANK | dead time, all anodes off (first DEAD_CYCLES of a slot)
// DRIVE | current digit driven from the buffer (rest of the slot)
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int NUM_DIGITS  = 4,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
  input  logic [3:0]                    wr_data,
  input  logic                          wr_dp,
  input  logic                          wr_blank,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(DIV);

  state_t                  state_q, state_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tick_q, tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  digit_t                  buf_q [NUM_DIGITS];
  digit_t                  cur;
  logic [6:0]              seg_dec;
  logic                    drive;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    case (state_q)
      BLANK: if (presc_q == PRE_W'(DEAD_CYCLES - 1)) state_d = DRIVE;
      DRIVE: begin
        if (presc_q == PRE_W'(DIV - 1)) begin
          state_d = BLANK;
          presc_d = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d  = '0;
            tick_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs are computed from the next state/index so they register on the
  // same edge as the FSM; the buffer is read pre-write, so a write shows up
  // one cycle after its edge.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) cur = buf_q[i];
    end
  end

  hex7_decode u_dec (
    .nibble_i (cur.data),
    .seg_o    (seg_dec)
  );

  always_comb begin
    drive = (state_d == DRIVE) && !cur.blank;
    an_d  = drive ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    seg_d = drive ? seg_dec : 7'h00;
    dp_d  = drive & cur.dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      presc_q <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= digit_t'{blank: 1'b1, dp: 1'b0, data: 4'h0};
      end
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      // Out-of-range indices match no entry and are dropped.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && wr_idx == IDX_W'(i)) begin
          buf_q[i] <= digit_t'{blank: wr_blank, dp: wr_dp, data: wr_data};
        end
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench: DIV = 10, DEAD_CYCLES = 2; a 4-digit and a 3-digit build.
module tb_seg_scan_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b1;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  logic       wr3_en = 1'b0;
  logic [1:0] wr3_idx = '0;
  logic [3:0] wr3_data = '0;
  logic       wr3_dp = 1'b0;
  logic       wr3_blank = 1'b1;
  logic [6:0] seg3;
  logic       dp3;
  logic [2:0] an3;
  logic       frame_tick3;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(100), .NUM_DIGITS(4), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  seg_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(100), .NUM_DIGITS(3), .DEAD_CYCLES(2)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr3_en), .wr_idx(wr3_idx), .wr_data(wr3_data),
    .wr_dp(wr3_dp), .wr_blank(wr3_blank), .seg(seg3), .dp(dp3), .an(an3),
    .frame_tick(frame_tick3)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] d, input logic p, input logic b);
    wr_idx = idx; wr_data = d; wr_dp = p; wr_blank = b; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    total_cnt++;
    if (an !== 4'b1111 || seg !== 7'h00 || dp !== 1'b0 || frame_tick !== 1'b0)
      $display("FAIL reset_state an=%b seg=%h dp=%b tick=%b required an=1111 seg=00 dp=0 tick=0",
               an, seg, dp, frame_tick);
    else pass_cnt++;
    total_cnt++;
    if (an3 !== 3'b111 || seg3 !== 7'h00)
      $display("FAIL reset_state3 an=%b seg=%h required an=111 seg=00", an3, seg3);
    else pass_cnt++;
  endtask

  task automatic test_idle();
    int ticks = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (frame_tick === 1'b1) ticks++;
      total_cnt++;
      if (an !== 4'b1111 || seg !== 7'h00)
        $display("FAIL idle_dark cyc=%0d an=%b seg=%h required an=1111 seg=00", cyc, an, seg);
      else pass_cnt++;
      total_cnt++;
      if (frame_tick !== (cyc == 40))
        $display("FAIL idle_tick cyc=%0d tick=%b required %b", cyc, frame_tick, (cyc == 40));
      else pass_cnt++;
    end
    total_cnt++;
    if (ticks != 1) $display("FAIL idle_tick_count got %0d required 1", ticks);
    else pass_cnt++;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an_t [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg_t [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    logic [3:0] ea;
    logic [6:0] es;
    wr(2'd0, 4'h1, 1'b0, 1'b0);
    wr(2'd1, 4'h2, 1'b0, 1'b0);
    wr(2'd2, 4'h3, 1'b0, 1'b0);
    wr(2'd3, 4'h4, 1'b0, 1'b0);
    while (cyc % 40 != 39) step();
    for (int k = 0; k < 40; k++) begin
      step();
      ea = (cyc % 10 < 2) ? 4'b1111 : exp_an_t[(cyc / 10) % 4];
      es = (cyc % 10 < 2) ? 7'h00 : exp_seg_t[(cyc / 10) % 4];
      total_cnt++;
      if (an !== ea || seg !== es || dp !== 1'b0)
        $display("FAIL scan cyc=%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=0",
                 cyc, an, seg, dp, ea, es);
      else pass_cnt++;
      total_cnt++;
      if (frame_tick !== (cyc % 40 == 0))
        $display("FAIL scan_tick cyc=%0d tick=%b required %b", cyc, frame_tick, (cyc % 40 == 0));
      else pass_cnt++;
    end
  endtask

  task automatic test_live_write();
    while (cyc % 40 != 4) step();
    wr(2'd0, 4'h8, 1'b1, 1'b0);
    total_cnt++;
    if (an !== 4'b1110 || seg !== 7'h06 || dp !== 1'b0)
      $display("FAIL live_write_edge an=%b seg=%h dp=%b required an=1110 seg=06 dp=0", an, seg, dp);
    else pass_cnt++;
    step();
    total_cnt++;
    if (an !== 4'b1110 || seg !== 7'h7F || dp !== 1'b1)
      $display("FAIL live_write_next an=%b seg=%h dp=%b required an=1110 seg=7f dp=1", an, seg, dp);
    else pass_cnt++;
    while (cyc % 40 != 9) step();
    total_cnt++;
    if (an !== 4'b1110 || seg !== 7'h7F)
      $display("FAIL live_write_slot_end an=%b seg=%h required an=1110 seg=7f", an, seg);
    else pass_cnt++;
    step();
    total_cnt++;
    if (an !== 4'b1111 || seg !== 7'h00 || dp !== 1'b0)
      $display("FAIL live_write_dead an=%b seg=%h dp=%b required an=1111 seg=00 dp=0", an, seg, dp);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (an !== 4'b1101 || seg !== 7'h5B)
      $display("FAIL live_write_next_slot an=%b seg=%h required an=1101 seg=5b", an, seg);
    else pass_cnt++;
  endtask

  task automatic test_advance_write();
    logic [2:0] ea;
    logic [6:0] es;
    while (cyc % 40 != 9) step();
    wr(2'd1, 4'hA, 1'b0, 1'b0);
    total_cnt++;
    if (an !== 4'b1111)
      $display("FAIL adv_write_dead an=%b required 1111", an);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (an !== 4'b1101 || seg !== 7'h77)
      $display("FAIL adv_write_first an=%b seg=%h required an=1101 seg=77", an, seg);
    else pass_cnt++;
    // 3-digit build: index 3 is out of range and must be dropped.
    wr3_idx = 2'd3; wr3_data = 4'h8; wr3_dp = 1'b1; wr3_blank = 1'b0; wr3_en = 1'b1;
    step();
    wr3_idx = 2'd0; wr3_data = 4'h5; wr3_dp = 1'b0; wr3_blank = 1'b0;
    step();
    wr3_en = 1'b0;
    while (cyc % 30 != 29) step();
    for (int k = 0; k < 30; k++) begin
      step();
      ea = (cyc % 10 >= 2 && (cyc / 10) % 3 == 0) ? 3'b110 : 3'b111;
      es = (ea == 3'b110) ? 7'h6D : 7'h00;
      total_cnt++;
      if (an3 !== ea || seg3 !== es || dp3 !== 1'b0)
        $display("FAIL oob_write cyc=%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=0",
                 cyc, an3, seg3, dp3, ea, es);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] ea;
    logic [6:0] es;
    while (cyc % 40 != 25) step();
    total_cnt++;
    if (an !== 4'b1011 || seg !== 7'h4F)
      $display("FAIL pre_reset_drive an=%b seg=%h required an=1011 seg=4f", an, seg);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    total_cnt++;
    if (an !== 4'b1111 || seg !== 7'h00 || dp !== 1'b0 || frame_tick !== 1'b0)
      $display("FAIL mid_reset an=%b seg=%h dp=%b tick=%b required an=1111 seg=00 dp=0 tick=0",
               an, seg, dp, frame_tick);
    else pass_cnt++;
    wr(2'd0, 4'h7, 1'b0, 1'b0);
    for (int k = 0; k < 38; k++) begin
      step();
      ea = (cyc % 10 >= 2 && cyc / 10 == 0) ? 4'b1110 : 4'b1111;
      es = (ea == 4'b1110) ? 7'h07 : 7'h00;
      total_cnt++;
      if (an !== ea || seg !== es)
        $display("FAIL post_reset cyc=%0d an=%b seg=%h required an=%b seg=%h", cyc, an, seg, ea, es);
      else pass_cnt++;
    end
  endtask

  task automatic test_blank_digit();
    logic [3:0] exp_an_t [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    logic [6:0] exp_seg_t [4] = '{7'h06, 7'h5B, 7'h4F, 7'h00};
    logic [3:0] ea;
    logic [6:0] es;
    wr(2'd0, 4'h1, 1'b0, 1'b0);
    wr(2'd1, 4'h2, 1'b0, 1'b0);
    wr(2'd2, 4'h3, 1'b0, 1'b0);
    wr(2'd3, 4'h4, 1'b1, 1'b1);
    while (cyc % 40 != 39) step();
    for (int k = 0; k < 40; k++) begin
      step();
      ea = (cyc % 10 < 2) ? 4'b1111 : exp_an_t[(cyc / 10) % 4];
      es = (cyc % 10 < 2) ? 7'h00 : exp_seg_t[(cyc / 10) % 4];
      total_cnt++;
      if (an !== ea || seg !== es || dp !== 1'b0)
        $display("FAIL blank_digit cyc=%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=0",
                 cyc, an, seg, dp, ea, es);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_scan();
    test_live_write();
    test_advance_write();
    test_mid_reset();
    test_blank_digit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
